// File: rtl/swt16_pkg.sv
// Shared widths and the byte-load extension helper for the swt16 pipeline.
package swt16_pkg;

    localparam int SWT16_WORD_W  = 16;
    localparam int SWT16_PC_W    = 12;
    localparam int SWT16_INSTR_W = 16;
    localparam int SWT16_IDX_W   = 4;
    localparam int SWT16_CNT_W   = 16;

    // Little-endian byte pick; signed extension takes priority when both flags are set.
    function automatic logic [SWT16_WORD_W-1:0] byte_extend(
        input logic [SWT16_WORD_W-1:0] word,
        input logic                    hi_sel,
        input logic                    sgn,
        input logic                    uns
    );
        logic [7:0] b;
        b = hi_sel ? word[15:8] : word[7:0];
        if (sgn)
            byte_extend = {{8{b[7]}}, b};
        else if (uns)
            byte_extend = {8'h00, b};
        else
            byte_extend = word;
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// Two-read, one-write register file with asynchronous clear of every entry.
module wb_regfile #(
    parameter int W     = 16,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [W-1:0]     i_wdata,
    input  logic [IDX_W-1:0] i_ridx1,
    input  logic [IDX_W-1:0] i_ridx2,
    output logic [W-1:0]     o_rdata1,
    output logic [W-1:0]     o_rdata2
);

    localparam int NREG = 2 ** IDX_W;

    logic [W-1:0] r_regs [NREG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_widx] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_ridx1];
    assign o_rdata2 = r_regs[i_ridx2];

endmodule

// File: rtl/wb.sv
// swt16 writeback stage: samples mem, extends byte loads, writes the register file
// with a forwarding view of the write, and counts retired instructions.
module wb
    import swt16_pkg::*;
#(
    parameter int IALU_WORD_WIDTH = SWT16_WORD_W,
    parameter int PC_WIDTH        = SWT16_PC_W,
    parameter int PMEM_WORD_WIDTH = SWT16_INSTR_W,
    parameter int REG_IDX_WIDTH   = SWT16_IDX_W,
    parameter int CNT_WIDTH       = SWT16_CNT_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem_byte_signed,
    input  logic                       in_act_load_dmem_byte_unsigned,
    input  logic                       in_act_write_res_to_reg,
    input  logic                       in_byte_sel,
    input  logic                       in_cnt_clear,
    input  logic [2:0]                 in_cycle_in_instr,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic                       in_instr_is_bubble,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [REG_IDX_WIDTH-1:0]   in_rs1_idx,
    input  logic [REG_IDX_WIDTH-1:0]   in_rs2_idx,
    output logic [IALU_WORD_WIDTH-1:0] out_rs1_word,
    output logic [IALU_WORD_WIDTH-1:0] out_rs2_word,
    output logic                       out_wb_en,
    output logic [REG_IDX_WIDTH-1:0]   out_wb_idx,
    output logic [IALU_WORD_WIDTH-1:0] out_wb_word,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [CNT_WIDTH-1:0]       out_retired_cnt
);

    logic                       r_sgn;
    logic                       r_uns;
    logic                       r_wr;
    logic                       r_sel;
    logic                       r_bub;
    logic [2:0]                 r_cyc;
    logic [PMEM_WORD_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]        r_pc;
    logic [IALU_WORD_WIDTH-1:0] r_res;
    logic [REG_IDX_WIDTH-1:0]   r_idx;
    logic [CNT_WIDTH-1:0]       r_cnt;

    logic                       w_wb_en;
    logic [IALU_WORD_WIDTH-1:0] w_wb_word;
    logic [IALU_WORD_WIDTH-1:0] w_rd1;
    logic [IALU_WORD_WIDTH-1:0] w_rd2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sgn   <= 1'b0;
            r_uns   <= 1'b0;
            r_wr    <= 1'b0;
            r_sel   <= 1'b0;
            r_bub   <= 1'b0;
            r_cyc   <= '0;
            r_instr <= '0;
            r_pc    <= '0;
            r_res   <= '0;
            r_idx   <= '0;
        end else begin
            r_sgn   <= in_act_load_dmem_byte_signed;
            r_uns   <= in_act_load_dmem_byte_unsigned;
            r_wr    <= in_act_write_res_to_reg;
            r_sel   <= in_byte_sel;
            r_bub   <= in_instr_is_bubble;
            r_cyc   <= in_cycle_in_instr;
            r_instr <= in_instr;
            r_pc    <= in_pc;
            r_res   <= in_res;
            r_idx   <= in_res_reg_idx;
        end
    end

    // Clear has priority over a same-edge retire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (in_cnt_clear)
            r_cnt <= '0;
        else if (!r_bub && r_cyc == 3'd0)
            r_cnt <= r_cnt + CNT_WIDTH'(1);
    end

    assign w_wb_en   = r_wr & ~r_bub;
    assign w_wb_word = byte_extend(r_res, r_sel, r_sgn, r_uns);

    wb_regfile #(
        .W     (IALU_WORD_WIDTH),
        .IDX_W (REG_IDX_WIDTH)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .i_we     (w_wb_en),
        .i_widx   (r_idx),
        .i_wdata  (w_wb_word),
        .i_ridx1  (in_rs1_idx),
        .i_ridx2  (in_rs2_idx),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Write-before-read: a reader of the register being written sees the new value now.
    assign out_rs1_word = (w_wb_en && in_rs1_idx == r_idx) ? w_wb_word : w_rd1;
    assign out_rs2_word = (w_wb_en && in_rs2_idx == r_idx) ? w_wb_word : w_rd2;

    assign out_wb_en       = w_wb_en;
    assign out_wb_idx      = r_idx;
    assign out_wb_word     = w_wb_word;
    assign out_instr       = r_instr;
    assign out_pc          = r_pc;
    assign out_retired_cnt = r_cnt;

endmodule
